// File: rtl/scratchpad_ram_initiator_if.sv
// Host request/response channels and the 64-bit scratchpad RAM port bundled together.
// The master modport is the initiator's view; slave is the host-plus-RAM side.
interface scratchpad_ram_initiator_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wr;
   logic [1:0]            req_len;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [63:0]           req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [63:0]           rsp_rdata;
   logic                  rsp_err;

   logic                  ram_en;
   logic                  ram_wr;
   logic [1:0]            ram_len;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [63:0]           ram_wdata;
   logic [63:0]           ram_rdata;

   modport master (
      input  req_valid, req_wr, req_len, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output ram_en, ram_wr, ram_len, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport slave (
      output req_valid, req_wr, req_len, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  ram_en, ram_wr, ram_len, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/scratchpad_ram_initiator.sv
// Single-outstanding request master for the 64-bit scratchpad RAM; short writes
// are done as read-modify-write because the RAM always writes all 8 bytes.
//
// state | meaning
// IDLE  | waiting for a host request (req_ready=1)
// RD    | one-cycle RAM read strobe
// CAP   | RAM read data valid; build response or merged write word
// WR    | one-cycle RAM write strobe
// RESP  | response held until rsp_ready
module scratchpad_ram_initiator #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   scratchpad_ram_initiator_if.master    bus,
   output logic                          busy
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      WR,
      RESP
   } state_t;

   // Highest start address whose 8-byte window stays inside the RAM.
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {{(ADDR_WIDTH-3){1'b1}}, 3'b000};

   state_t                state_q, state_d;
   logic                  wr_q;
   logic [1:0]            len_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [63:0]           wdata_q;
   logic [63:0]           ram_wdata_q;
   logic [63:0]           rsp_rdata_q;
   logic                  rsp_err_q;

   logic                  accept;
   logic                  range_err;
   logic                  full_wr;
   logic [63:0]           byte_mask;

   function automatic logic [63:0] len_mask(input logic [1:0] len);
      logic [63:0] m;
      case (len)
         2'd0:    m = 64'h0000_0000_0000_00FF;
         2'd1:    m = 64'h0000_0000_0000_FFFF;
         2'd2:    m = 64'h0000_0000_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

   assign accept    = bus.req_valid && (state_q == IDLE);
   assign range_err = bus.req_addr > ADDR_MAX;
   assign full_wr   = bus.req_wr && (bus.req_len == 2'd3);
   assign byte_mask = len_mask(len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (range_err) begin
                  state_d = RESP;
               end else if (full_wr) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD:      state_d = CAP;
         CAP:     state_d = wr_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q        <= 1'b0;
         len_q       <= 2'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ram_wdata_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (accept) begin
            wr_q        <= bus.req_wr;
            len_q       <= bus.req_len;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            rsp_err_q   <= range_err;
            rsp_rdata_q <= '0;
            if (full_wr) begin
               ram_wdata_q <= bus.req_wdata;
            end
         end
         if (state_q == CAP) begin
            if (wr_q) begin
               ram_wdata_q <= (wdata_q & byte_mask) | (bus.ram_rdata & ~byte_mask);
            end else begin
               rsp_rdata_q <= bus.ram_rdata & byte_mask;
            end
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.ram_en    = (state_q == RD) || (state_q == WR);
   assign bus.ram_wr    = (state_q == WR);
   assign bus.ram_len   = 2'b11;
   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_scratchpad_ram_initiator.sv
// Directed bench for scratchpad_ram_initiator with a byte-array RAM model.
module tb_scratchpad_ram_initiator;

   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   scratchpad_ram_initiator_if #(.ADDR_WIDTH(AW)) bus();

   scratchpad_ram_initiator #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master),
      .busy  (busy)
   );

   logic [7:0] mem [0:(1<<AW)-1];
   int ram_wr_cnt = 0;
   int n_cmp = 0;
   int n_bad = 0;

   // RAM model: 8-byte little-endian window, read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_wr) begin
            for (int k = 0; k < 8; k++) begin
               if (int'(bus.ram_addr) + k < (1<<AW)) mem[int'(bus.ram_addr) + k] = bus.ram_wdata[8*k +: 8];
            end
            ram_wr_cnt++;
         end else begin
            logic [63:0] d;
            d = '0;
            for (int k = 0; k < 8; k++) begin
               if (int'(bus.ram_addr) + k < (1<<AW)) d[8*k +: 8] = mem[int'(bus.ram_addr) + k];
            end
            bus.ram_rdata <= d;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xact(input logic wr, input logic [1:0] len, input logic [AW-1:0] addr,
                       input logic [63:0] wd, input int hold,
                       output logic [63:0] rd, output logic err, output int lat,
                       output int n_rd, output int n_wr, output logic [63:0] wseen);
      n_rd = 0; n_wr = 0; wseen = '0; lat = 0;
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_len   = len;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 16) begin
         if (bus.ram_en && !bus.ram_wr) n_rd++;
         if (bus.ram_en && bus.ram_wr) begin
            n_wr++;
            wseen = bus.ram_wdata;
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.rsp_valid) chk("rsp_timeout", bus.rsp_valid, 1);
      rd  = bus.rsp_rdata;
      err = bus.rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", bus.rsp_valid, 1);
         chk("hold_rdata", bus.rsp_rdata, rd);
         chk("hold_err",   bus.rsp_err, err);
         chk("hold_ready", bus.req_ready, 0);
         chk("hold_ram_en", bus.ram_en, 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("ready_after_hs", bus.req_ready, 1);
      chk("valid_after_hs", bus.rsp_valid, 0);
   endtask

   initial begin
      logic [63:0] rd, ws;
      logic        err;
      int          lat, nr, nw, wc;

      for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_len   = 2'd0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.ram_rdata = '0;

      // Reset state
      #1;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_ram_en",    bus.ram_en, 0);
      chk("rst_ram_len",   bus.ram_len, 2'b11);
      chk("rst_busy",      busy, 0);
      chk("rst_rdata",     bus.rsp_rdata, 0);
      chk("rst_ram_addr",  bus.ram_addr, 0);
      chk("rst_ram_wdata", bus.ram_wdata, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", bus.req_ready, 1);

      // Full write then read
      xact(1'b1, 2'd3, 10'h010, 64'h1122334455667788, 0, rd, err, lat, nr, nw, ws);
      chk("fw_lat", lat, 2);
      chk("fw_nrd", nr, 0);
      chk("fw_nwr", nw, 1);
      chk("fw_wdata", ws, 64'h1122334455667788);
      chk("fw_rdata", rd, 0);
      chk("fw_err", err, 0);
      xact(1'b0, 2'd3, 10'h010, 64'h0, 0, rd, err, lat, nr, nw, ws);
      chk("rd_data", rd, 64'h1122334455667788);
      chk("rd_err", err, 0);
      chk("rd_lat", lat, 3);
      chk("rd_nrd", nr, 1);

      // Partial write preserves neighbours
      for (int i = 0; i < 8; i++) mem[16 + i] = 8'hFF;
      xact(1'b1, 2'd1, 10'h010, 64'hAAAAAAAAAAAABEEF, 0, rd, err, lat, nr, nw, ws);
      chk("pw_lat", lat, 4);
      chk("pw_nrd", nr, 1);
      chk("pw_nwr", nw, 1);
      chk("pw_wdata", ws, 64'hFFFFFFFFFFFFBEEF);
      chk("pw_rdata", rd, 0);
      xact(1'b0, 2'd3, 10'h010, 64'h0, 0, rd, err, lat, nr, nw, ws);
      chk("pw_readback", rd, 64'hFFFFFFFFFFFFBEEF);

      // Zero extension on short unaligned reads
      xact(1'b0, 2'd0, 10'h011, 64'h0, 0, rd, err, lat, nr, nw, ws);
      chk("zx_len0", rd, 64'h00000000000000BE);
      xact(1'b0, 2'd1, 10'h011, 64'h0, 0, rd, err, lat, nr, nw, ws);
      chk("zx_len1", rd, 64'h000000000000FFBE);

      // Unaligned 4-byte write straddling into zeroed memory
      xact(1'b1, 2'd2, 10'h013, 64'h12345678DEADC0DE, 0, rd, err, lat, nr, nw, ws);
      chk("uw_wdata", ws, 64'h000000FFDEADC0DE);
      xact(1'b0, 2'd3, 10'h010, 64'h0, 0, rd, err, lat, nr, nw, ws);
      chk("uw_readback", rd, 64'hFFDEADC0DEFFBEEF);

      // Range errors and the last legal address
      xact(1'b0, 2'd3, 10'h3F9, 64'h0, 0, rd, err, lat, nr, nw, ws);
      chk("re_err", err, 1);
      chk("re_rdata", rd, 0);
      chk("re_lat", lat, 1);
      chk("re_ram", nr + nw, 0);
      wc = ram_wr_cnt;
      xact(1'b1, 2'd0, 10'h3FF, 64'hFF, 0, rd, err, lat, nr, nw, ws);
      chk("we_err", err, 1);
      chk("we_nowrite", ram_wr_cnt - wc, 0);
      xact(1'b1, 2'd3, 10'h3F8, 64'hCAFEF00D12345678, 0, rd, err, lat, nr, nw, ws);
      chk("edge_w_err", err, 0);
      xact(1'b0, 2'd3, 10'h3F8, 64'h0, 0, rd, err, lat, nr, nw, ws);
      chk("edge_r_err", err, 0);
      chk("edge_r_data", rd, 64'hCAFEF00D12345678);

      // Back-pressure in RESP
      xact(1'b0, 2'd2, 10'h010, 64'h0, 10, rd, err, lat, nr, nw, ws);
      chk("bp_data", rd, 64'h00000000DEFFBEEF);

      // Reset in CAP of a one-byte write
      mem[32] = 8'h77;
      wc = ram_wr_cnt;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_len   = 2'd0;
      bus.req_addr  = 10'h020;
      bus.req_wdata = 64'h55;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("mr_busy_cap", busy, 1);
      chk("mr_en_cap", bus.ram_en, 0);
      rst_n = 1'b0;
      #1;
      chk("mr_ram_en", bus.ram_en, 0);
      chk("mr_busy", busy, 0);
      chk("mr_rsp_valid", bus.rsp_valid, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("mr_nowrite", ram_wr_cnt - wc, 0);
      chk("mr_mem", mem[32], 8'h77);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mr_req_ready", bus.req_ready, 1);
      chk("mr_rsp_valid_post", bus.rsp_valid, 0);
      xact(1'b0, 2'd0, 10'h020, 64'h0, 0, rd, err, lat, nr, nw, ws);
      chk("mr_readback", rd, 64'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/scratchpad_ram_initiator.md
Name: scratchpad_ram_initiator

Overview:
- Request-side master for the byte-addressed 64-bit scratchpad RAM port (en/wr/len/addr/wdata/rdata).
- Accepts one host request at a time over valid/ready and drives the RAM port.
- The RAM writes all 8 bytes on every write, zeroing bytes above len. This block therefore performs read-modify-write for writes shorter than 8 bytes, so neighbouring bytes are preserved.
- Returns zero-extended read data, or write completion, on a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 10, RAM byte-address width; must be >= 4; RAM size is 2**ADDR_WIDTH bytes.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  host request present
- req_ready  output  1  block can accept a request
- req_wr  input  1  1=write, 0=read
- req_len  input  2  access size: 0=1B, 1=2B, 2=4B, 3=8B
- req_addr  input  ADDR_WIDTH  byte address (unaligned allowed)
- req_wdata  input  64  write data; byte k in bits [8k+7:8k]
- rsp_valid  output  1  response present
- rsp_ready  input  1  host accepts response
- rsp_rdata  output  64  read data, zero-extended above len; 0 for writes
- rsp_err  output  1  address range error
- ram_en  output  1  RAM access strobe
- ram_wr  output  1  RAM write select
- ram_len  output  2  RAM length; always driven 2'b11
- ram_addr  output  ADDR_WIDTH  RAM byte address
- ram_wdata  output  64  RAM write data
- ram_rdata  input  64  RAM read data, valid the cycle after a read strobe
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - rsp_valid, rsp_err, ram_en and ram_wr are 0; ram_len is 2'b11.
  - rsp_rdata, ram_addr and ram_wdata are 0; busy is 0.
  - req_ready is 1 once rst_n deasserts.
- Reset mid-operation: the operation is aborted immediately. No RAM write is issued afterwards, and any pending response is discarded.
- req_ready = (state==IDLE). A request is accepted on a posedge with req_valid & req_ready. At acceptance, wr/len/addr/wdata are registered.
- nbytes = 1<<len.
- Range check at acceptance: if req_addr > 2**ADDR_WIDTH-8, the request is an error. Next state is RESP with rsp_err=1 and rsp_rdata=0, and no RAM access is made. This prevents RAM index wrap.
- States: IDLE, RD, CAP, WR, RESP.
  - IDLE -> RESP on error.
  - IDLE -> WR on a write with len=3.
  - IDLE -> RD on a read, or on a write with len<3.
  - RD: ram_en=1, ram_wr=0 for exactly one cycle; -> CAP.
  - CAP: capture ram_rdata. On a read, rsp_rdata = captured bytes k<nbytes, 0 above; -> RESP. On a write, build merged = req byte k for k<nbytes, captured byte otherwise; -> WR.
  - WR: ram_en=1, ram_wr=1, ram_wdata = merged (len<3) or req_wdata (len=3), for exactly one cycle; -> RESP.
  - RESP: rsp_valid=1, held stable until rsp_ready; on the handshake -> IDLE.
- ram_en=0 outside RD/WR. ram_addr holds the registered address in all non-IDLE states.
- Latency from the accept edge to rsp_valid:
  - read: 3 cycles
  - full write: 2 cycles
  - partial write: 4 cycles
  - error: 1 cycle
- Throughput: one request per response handshake. A new request can be accepted on the cycle after the handshake.
- Back-pressure: rsp_ready=0 stalls in RESP indefinitely with all outputs stable.
- rsp_err=0 and rsp_rdata=0 for successful writes.
- Unaligned accesses are legal whenever the range check passes.

Test Plan:
1. Full write then read: write addr 0x010, len=3, wdata 0x1122334455667788. Read back addr 0x010, len=3. Expect rsp_rdata 0x1122334455667788, rsp_err=0, read latency 3 cycles.
2. Partial write preservation: preload 0x010 with 0xFFFFFFFFFFFFFFFF. Write len=1, wdata 0xAAAAAAAAAAAABEEF. Expect the RAM bus to show RD then WR with ram_wdata 0xFFFFFFFFFFFFBEEF. A read len=3 returns 0xFFFFFFFFFFFFBEEF.
3. Read zero-extension: with memory from test 2, read addr 0x011, len=0. Expect rsp_rdata 0x00000000000000BE.
4. Range error: ADDR_WIDTH=10, read addr 0x3F9. Expect rsp_err=1, rsp_rdata=0, ram_en never asserted, rsp_valid 1 cycle after accept. Addr 0x3F8 succeeds.
5. Back-pressure: hold rsp_ready=0 for 10 cycles in RESP. Expect rsp_valid and rsp_rdata stable and req_ready=0 throughout; after the handshake, req_ready=1 the next cycle.
6. Reset mid-RMW: assert rst_n=0 in CAP of a len=0 write. Expect ram_en=0 immediately, no WR cycle, memory unchanged, and req_ready=1 after release.
